// File: rtl/gemm_pkg.sv
// gemm_pkg: shared GEMM instruction/micro-op layouts, widths and FSM states.
package gemm_pkg;
    localparam int UPC_W  = 13;
    localparam int ITER_W = 14;
    localparam int ACC_W  = 11;
    localparam int INP_W  = 11;
    localparam int WGT_W  = 10;
    localparam logic [2:0] OP_GEMM = 3'd2;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef struct packed {
        logic              pad_hi;
        logic [WGT_W-1:0]  wgt_fi;
        logic [WGT_W-1:0]  wgt_fo;
        logic [INP_W-1:0]  src_fi;
        logic [INP_W-1:0]  src_fo;
        logic [ACC_W-1:0]  dst_fi;
        logic [ACC_W-1:0]  dst_fo;
        logic [ITER_W-1:0] iter_in;
        logic [ITER_W-1:0] iter_out;
        logic [ITER_W-1:0] uop_end;
        logic [UPC_W-1:0]  uop_bgn;
        logic              rflag;
        logic [3:0]        pad_lo;
        logic [2:0]        opcode;
    } insn_t;
    typedef struct packed {
        logic [WGT_W-1:0] wgt;
        logic [INP_W-1:0] src;
        logic [ACC_W-1:0] dst;
    } uop_t;
    function automatic logic is_empty(input insn_t d);
        return d.opcode != OP_GEMM || d.uop_end <= {1'b0, d.uop_bgn} || d.iter_out == '0 || d.iter_in == '0;
    endfunction
endpackage

// File: rtl/gemm_loop_cnt.sv
// gemm_loop_cnt: 3-level nested loop counter with running-sum index offsets.
module gemm_loop_cnt
    import gemm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [UPC_W-1:0]  i_bgn,
    input  logic [ITER_W-1:0] i_end,
    input  logic [ITER_W-1:0] i_iter_out,
    input  logic [ITER_W-1:0] i_iter_in,
    input  logic [ACC_W-1:0]  i_dst_fo,
    input  logic [ACC_W-1:0]  i_dst_fi,
    input  logic [INP_W-1:0]  i_src_fo,
    input  logic [INP_W-1:0]  i_src_fi,
    input  logic [WGT_W-1:0]  i_wgt_fo,
    input  logic [WGT_W-1:0]  i_wgt_fi,
    output logic [UPC_W-1:0]  o_upc,
    output logic              o_last,
    output logic [ACC_W-1:0]  o_dst_off,
    output logic [INP_W-1:0]  o_src_off,
    output logic [WGT_W-1:0]  o_wgt_off
);
    logic [UPC_W-1:0]  r_upc, r_bgn;
    logic [ITER_W-1:0] r_i_out, r_i_in;
    logic [ACC_W-1:0]  r_dst_out, r_dst_in;
    logic [INP_W-1:0]  r_src_out, r_src_in;
    logic [WGT_W-1:0]  r_wgt_out, r_wgt_in;
    logic              w_upc_wrap, w_in_wrap, w_out_wrap;

    assign w_upc_wrap = {1'b0, r_upc} + ITER_W'(1) == i_end;
    assign w_in_wrap  = r_i_in + ITER_W'(1) == i_iter_in;
    assign w_out_wrap = r_i_out + ITER_W'(1) == i_iter_out;
    assign o_last     = w_upc_wrap & w_in_wrap & w_out_wrap;
    assign o_upc      = r_upc;
    assign o_dst_off  = r_dst_out + r_dst_in;
    assign o_src_off  = r_src_out + r_src_in;
    assign o_wgt_off  = r_wgt_out + r_wgt_in;

    always_ff @(posedge clk) begin
        if (rst || (i_en && i_load)) begin
            r_upc     <= rst ? '0 : i_bgn;
            r_bgn     <= rst ? '0 : i_bgn;
            r_i_out   <= '0;
            r_i_in    <= '0;
            r_dst_out <= '0;
            r_dst_in  <= '0;
            r_src_out <= '0;
            r_src_in  <= '0;
            r_wgt_out <= '0;
            r_wgt_in  <= '0;
        end else if (i_en && i_step && !o_last) begin
            r_upc <= w_upc_wrap ? r_bgn : r_upc + UPC_W'(1);
            if (w_upc_wrap) begin
                r_i_in   <= w_in_wrap ? '0 : r_i_in + ITER_W'(1);
                r_dst_in <= w_in_wrap ? '0 : r_dst_in + i_dst_fi;
                r_src_in <= w_in_wrap ? '0 : r_src_in + i_src_fi;
                r_wgt_in <= w_in_wrap ? '0 : r_wgt_in + i_wgt_fi;
                if (w_in_wrap) begin
                    r_i_out   <= r_i_out + ITER_W'(1);
                    r_dst_out <= r_dst_out + i_dst_fo;
                    r_src_out <= r_src_out + i_src_fo;
                    r_wgt_out <= r_wgt_out + i_wgt_fo;
                end
            end
        end
    end
endmodule

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: GEMM instruction sequencer emitting one resolved index triple per cycle.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int INS_WIDTH     = 128,
    parameter int UOP_WIDTH     = 32,
    parameter int UPC_WIDTH     = 13,
    parameter int ACC_IDX_WIDTH = 11,
    parameter int INP_IDX_WIDTH = 11,
    parameter int WGT_IDX_WIDTH = 10,
    parameter int UOP_RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [INS_WIDTH-1:0]     i_insn,
    input  logic                     i_insn_valid,
    output logic                     o_insn_ready,
    output logic [UPC_WIDTH-1:0]     o_upc,
    input  logic [UOP_WIDTH-1:0]     i_uop,
    output logic                     o_issue_valid,
    output logic                     o_issue_reset,
    output logic [ACC_IDX_WIDTH-1:0] o_acc_idx,
    output logic [INP_IDX_WIDTH-1:0] o_inp_idx,
    output logic [WGT_IDX_WIDTH-1:0] o_wgt_idx,
    output logic                     o_done,
    output logic                     o_busy
);
    insn_t                 r_insn, w_dec;
    uop_t                  w_uop;
    state_t                r_state;
    logic                  w_last, w_unused;
    logic [ACC_W-1:0]      w_dst_off;
    logic [INP_W-1:0]      w_src_off;
    logic [WGT_W-1:0]      w_wgt_off;
    logic [UOP_RD_LAT-1:0] r_dv;
    logic [ACC_W-1:0]      r_dst_off [UOP_RD_LAT];
    logic [INP_W-1:0]      r_src_off [UOP_RD_LAT];
    logic [WGT_W-1:0]      r_wgt_off [UOP_RD_LAT];

    assign w_dec    = insn_t'(i_insn);
    assign w_uop    = uop_t'(i_uop);
    assign w_unused = ^{r_insn.pad_hi, r_insn.pad_lo, r_insn.opcode, r_insn.uop_bgn};

    gemm_loop_cnt u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_load    (r_state == S_IDLE && i_insn_valid),
        .i_step    (r_state == S_RUN),
        .i_bgn     (w_dec.uop_bgn),
        .i_end     (r_insn.uop_end),
        .i_iter_out(r_insn.iter_out),
        .i_iter_in (r_insn.iter_in),
        .i_dst_fo  (r_insn.dst_fo),
        .i_dst_fi  (r_insn.dst_fi),
        .i_src_fo  (r_insn.src_fo),
        .i_src_fi  (r_insn.src_fi),
        .i_wgt_fo  (r_insn.wgt_fo),
        .i_wgt_fi  (r_insn.wgt_fi),
        .o_upc     (o_upc),
        .o_last    (w_last),
        .o_dst_off (w_dst_off),
        .o_src_off (w_src_off),
        .o_wgt_off (w_wgt_off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_insn       <= '0;
            o_insn_ready <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else if (i_en) begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_insn_valid) begin
                    r_insn       <= w_dec;
                    o_insn_ready <= 1'b0;
                    o_busy       <= 1'b1;
                    r_state      <= is_empty(w_dec) ? S_DRAIN : S_RUN;
                end
                S_RUN: if (w_last) r_state <= S_DRAIN;
                default: if (r_dv == '0) begin
                    o_done       <= 1'b1;
                    o_insn_ready <= 1'b1;
                    o_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // offsets travel alongside the outstanding micro-op read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv          <= '0;
            o_issue_valid <= 1'b0;
            o_issue_reset <= 1'b0;
            o_acc_idx     <= '0;
            o_inp_idx     <= '0;
            o_wgt_idx     <= '0;
            for (int k = 0; k < UOP_RD_LAT; k++) begin
                r_dst_off[k] <= '0;
                r_src_off[k] <= '0;
                r_wgt_off[k] <= '0;
            end
        end else if (i_en) begin
            r_dv[0]       <= r_state == S_RUN;
            r_dst_off[0]  <= w_dst_off;
            r_src_off[0]  <= w_src_off;
            r_wgt_off[0]  <= w_wgt_off;
            for (int k = 1; k < UOP_RD_LAT; k++) begin
                r_dv[k]      <= r_dv[k-1];
                r_dst_off[k] <= r_dst_off[k-1];
                r_src_off[k] <= r_src_off[k-1];
                r_wgt_off[k] <= r_wgt_off[k-1];
            end
            o_issue_valid <= r_dv[UOP_RD_LAT-1];
            o_issue_reset <= r_dv[UOP_RD_LAT-1] & r_insn.rflag;
            o_acc_idx     <= w_uop.dst + r_dst_off[UOP_RD_LAT-1];
            o_inp_idx     <= w_uop.src + r_src_off[UOP_RD_LAT-1];
            o_wgt_idx     <= w_uop.wgt + r_wgt_off[UOP_RD_LAT-1];
        end
    end
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: directed checks of the GEMM sequencer against hand-computed index streams.
module tb_gemm_seq_ctrl;
    logic         clk, rst, en, insn_valid, insn_ready, issue_valid, issue_reset, done, busy;
    logic [127:0] insn;
    logic [12:0]  upc;
    logic [31:0]  uop;
    logic [10:0]  acc_idx, inp_idx;
    logic [9:0]   wgt_idx;
    logic [31:0]  mem [8192];
    int           vec, miss;

    gemm_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_insn       (insn),
        .i_insn_valid (insn_valid),
        .o_insn_ready (insn_ready),
        .o_upc        (upc),
        .i_uop        (uop),
        .o_issue_valid(issue_valid),
        .o_issue_reset(issue_reset),
        .o_acc_idx    (acc_idx),
        .o_inp_idx    (inp_idx),
        .o_wgt_idx    (wgt_idx),
        .o_done       (done),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (en) uop <= mem[upc];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int op, input int rf, input int bgn, input int fin,
                                         input int io, input int ii, input int dfo, input int dfi,
                                         input int sfo, input int sfi, input int wfo, input int wfi);
        logic [127:0] w;
        w = '0;
        w[2:0]     = 3'(op);
        w[7]       = 1'(rf);
        w[20:8]    = 13'(bgn);
        w[34:21]   = 14'(fin);
        w[48:35]   = 14'(io);
        w[62:49]   = 14'(ii);
        w[73:63]   = 11'(dfo);
        w[84:74]   = 11'(dfi);
        w[95:85]   = 11'(sfo);
        w[106:96]  = 11'(sfi);
        w[116:107] = 10'(wfo);
        w[126:117] = 10'(wfi);
        return w;
    endfunction

    function automatic logic [31:0] mkuop(input int d, input int s, input int g);
        return {10'(g), 11'(s), 11'(d)};
    endfunction

    task automatic accept(input logic [127:0] w);
        insn       = w;
        insn_valid = 1'b1;
        chk("ready_before_accept", 0, 32'(insn_ready), 32'd1);
        tick();
        insn_valid = 1'b0;
    endtask

    initial begin
        int u, i, o, k;
        logic e;
        vec = 0;
        miss = 0;
        for (int a = 0; a < 8192; a++) mem[a] = '0;
        rst = 1'b1;
        en = 1'b1;
        insn = '0;
        insn_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_ready", 0, 32'(insn_ready), 32'd1);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_valid", 0, 32'(issue_valid), 32'd0);
        chk("rst_ireset", 0, 32'(issue_reset), 32'd0);
        chk("rst_upc", 0, 32'(upc), 32'd0);
        chk("rst_acc", 0, 32'(acc_idx), 32'd0);
        chk("rst_inp", 0, 32'(inp_idx), 32'd0);
        chk("rst_wgt", 0, 32'(wgt_idx), 32'd0);
        tick();

        mem[1] = mkuop(4, 8, 3);
        accept(mk(2, 0, 1, 2, 16, 1, 1, 0, 1, 0, 0, 0));
        for (int c = 1; c <= 20; c++) begin
            e = c >= 3 && c <= 18;
            chk("nom_valid", c, 32'(issue_valid), 32'(e));
            if (e) begin
                chk("nom_acc", c, 32'(acc_idx), 32'(4 + c - 3));
                chk("nom_inp", c, 32'(inp_idx), 32'(8 + c - 3));
                chk("nom_wgt", c, 32'(wgt_idx), 32'd3);
            end
            chk("nom_done", c, 32'(done), 32'(c == 19));
            chk("nom_upc", c, 32'(upc), 32'd1);
            chk("nom_busy", c, 32'(busy), 32'(c <= 18));
            chk("nom_ready", c, 32'(insn_ready), 32'(c >= 19));
            tick();
        end

        mem[0] = mkuop(100, 50, 7);
        mem[1] = mkuop(200, 60, 9);
        accept(mk(2, 0, 0, 2, 2, 3, 10, 1, 0, 2, 5, 0));
        for (int c = 1; c <= 16; c++) begin
            e = c >= 3 && c <= 14;
            chk("nest_valid", c, 32'(issue_valid), 32'(e));
            if (e) begin
                k = c - 3;
                u = k % 2;
                i = (k / 2) % 3;
                o = k / 6;
                chk("nest_acc", c, 32'(acc_idx), 32'((u != 0 ? 200 : 100) + 10 * o + i));
                chk("nest_inp", c, 32'(inp_idx), 32'((u != 0 ? 60 : 50) + 2 * i));
                chk("nest_wgt", c, 32'(wgt_idx), 32'((u != 0 ? 9 : 7) + 5 * o));
            end
            chk("nest_done", c, 32'(done), 32'(c == 15));
            tick();
        end

        for (int n = 0; n < 2; n++) begin
            accept(n == 0 ? mk(2, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0) : mk(3, 0, 0, 2, 2, 3, 0, 0, 0, 0, 0, 0));
            for (int c = 1; c <= 3; c++) begin
                chk("empty_valid", c, 32'(issue_valid), 32'd0);
                chk("empty_done", c, 32'(done), 32'(c == 2));
                chk("empty_ready", c, 32'(insn_ready), 32'(c >= 2));
                tick();
            end
        end

        mem[5] = mkuop(2040, 0, 0);
        accept(mk(2, 1, 5, 6, 2, 1, 8, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 6; c++) begin
            e = c == 3 || c == 4;
            chk("wrap_valid", c, 32'(issue_valid), 32'(e));
            chk("wrap_ireset", c, 32'(issue_reset), 32'(e));
            if (e) chk("wrap_acc", c, 32'(acc_idx), c == 3 ? 32'd2040 : 32'd0);
            chk("wrap_done", c, 32'(done), 32'(c == 5));
            tick();
        end

        mem[1] = mkuop(4, 8, 3);
        accept(mk(2, 0, 1, 2, 6, 1, 1, 0, 1, 0, 0, 0));
        for (int c = 1; c <= 14; c++) begin
            en = !(c >= 4 && c <= 6);
            e = c >= 3 && c <= 11;
            chk("stall_valid", c, 32'(issue_valid), 32'(e));
            if (e) chk("stall_acc", c, 32'(acc_idx), 32'(c <= 4 ? 4 + c - 3 : c <= 7 ? 5 : 6 + c - 8));
            chk("stall_done", c, 32'(done), 32'(c == 12));
            chk("stall_upc", c, 32'(upc), 32'd1);
            tick();
        end
        en = 1'b1;

        accept(mk(2, 0, 1, 2, 16, 1, 1, 0, 1, 0, 0, 0));
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 0, 32'(insn_ready), 32'd1);
        chk("abort_valid", 0, 32'(issue_valid), 32'd0);
        chk("abort_busy", 0, 32'(busy), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            chk("abort_done", c, 32'(done), 32'd0);
            chk("abort_quiet", c, 32'(issue_valid), 32'd0);
            tick();
        end
        accept(mk(2, 0, 1, 2, 2, 1, 1, 0, 1, 0, 0, 0));
        for (int c = 1; c <= 6; c++) begin
            e = c == 3 || c == 4;
            chk("fresh_valid", c, 32'(issue_valid), 32'(e));
            if (e) begin
                chk("fresh_acc", c, 32'(acc_idx), 32'(4 + c - 3));
                chk("fresh_inp", c, 32'(inp_idx), 32'(8 + c - 3));
            end
            chk("fresh_done", c, 32'(done), 32'(c == 5));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/gemm_seq_ctrl.md
Name: gemm_seq_ctrl

Overview:
Sequencer that accepts one 128-bit GEMM instruction at a time and walks its nested loop: outer iter_out, inner iter_in, innermost micro-op range [uop_bgn, uop_end).
- Drives the micro-op memory address (upc) and captures the returned 32-bit micro-op.
- Emits one fully resolved (acc, inp, wgt) index triple per cycle to the GEMM datapath.
- Sits between the instruction fetch/queue and the gemm datapath, ahead of the acc/inp/wgt buffers.

Parameters:
- INS_WIDTH, 128, instruction width
- UOP_WIDTH, 32, micro-op width
- UPC_WIDTH, 13, micro-op address width
- ACC_IDX_WIDTH, 11, accumulator index width (arithmetic wraps mod 2^ACC_IDX_WIDTH)
- INP_IDX_WIDTH, 11, input index width
- WGT_IDX_WIDTH, 10, weight index width
- UOP_RD_LAT, 1, micro-op memory read latency in cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when 0, all state and outputs hold, matching the BRAM enables
- insn  in  INS_WIDTH  instruction; sampled only on handshake
- insn_valid  in  1  instruction offered
- insn_ready  out  1  controller idle, can accept
- upc  out  UPC_WIDTH  micro-op memory address
- uop  in  UOP_WIDTH  micro-op read data, valid UOP_RD_LAT cycles after upc
- issue_valid  out  1  index triple valid this cycle
- issue_reset  out  1  copy of insn[7]; datapath zeroes acc instead of MAC
- acc_idx  out  ACC_IDX_WIDTH  accumulator row index
- inp_idx  out  INP_IDX_WIDTH  input row index
- wgt_idx  out  WGT_IDX_WIDTH  weight row index
- done  out  1  one-cycle pulse when the instruction fully retires
- busy  out  1  high from handshake until done

Behaviour:
- Reset: the clk edge with rst=1 forces state IDLE.
  - insn_ready=1; upc, issue_valid, issue_reset, acc/inp/wgt_idx, done, busy all 0.
  - All counters, offsets and delay-line valids cleared.
  - Reset mid-instruction aborts it: no done pulse; in-flight micro-ops are discarded.
- en=0 freezes everything, including the delay-line valids. rst overrides en.
- Instruction fields:
  - [2:0] opcode
  - [7] reset flag
  - [20:8] uop_bgn
  - [34:21] uop_end
  - [48:35] iter_out
  - [62:49] iter_in
  - [73:63] dst_factor_out
  - [84:74] dst_factor_in
  - [95:85] src_factor_out
  - [106:96] src_factor_in
  - [116:107] wgt_factor_out
  - [126:117] wgt_factor_in
- Micro-op fields: [10:0] dst, [21:11] src, [31:22] wgt.
- Handshake: an instruction is accepted on the edge where insn_valid & insn_ready & en. insn is latched whole at that edge.
- FSM states:
  - IDLE: insn_ready=1. On accept, go to RUN; if the instruction is empty, go to DRAIN.
  - RUN: one upc per enabled cycle, starting at uop_bgn. After the last (i_out, i_in, upc) point, go to DRAIN.
  - DRAIN: wait until the delay line is empty, then pulse done for 1 cycle and return to IDLE.
- Empty instruction: opcode != 2, or uop_end <= uop_bgn, or iter_out == 0, or iter_in == 0. It produces zero issues and done is asserted 2 cycles after accept.
- Loop order:
  - upc increments innermost.
  - At the wrap from uop_end-1 back to uop_bgn, i_in increments.
  - At the i_in wrap, i_out increments.
  - Total issues = iter_out * iter_in * (uop_end - uop_bgn).
- Offsets:
  - Kept as running sums; no multipliers.
  - out_off += factor_out at each i_out step; in_off is reset to 0 there.
  - in_off += factor_in at each i_in step.
- Index arithmetic:
  - acc_idx = uop.dst + dst_out_off + dst_in_off, truncated to ACC_IDX_WIDTH.
  - inp_idx and wgt_idx follow the same rule with the src and wgt factors and widths.
  - The offsets used are those belonging to the upc issue cycle; they travel with the micro-op through a delay line of depth UOP_RD_LAT.
- Latency:
  - Accept at edge 0.
  - First upc is driven in cycle 1.
  - The matching uop arrives in cycle 1+UOP_RD_LAT.
  - issue_valid and the registered indices appear one cycle after the uop arrives, i.e. cycle 3 for the default.
  - Throughput is 1 issue per enabled cycle.
- done fires the cycle after the last issue_valid. insn_ready returns to 1 in the same cycle, so back-to-back instructions are accepted with a 1-cycle gap minimum.
- insn_valid while busy is ignored; insn_ready=0 during RUN and DRAIN.
- upc holds its last value in IDLE.

Decomposition:
- Shared package gemm_pkg:
  - Instruction field bit positions and the GEMM opcode constant (2).
  - Micro-op field positions.
  - The index widths.
- Sub-module gemm_loop_cnt: a 3-level nested counter with wrap flags plus the running offset accumulators.
- The top level handles the FSM, the upc delay line and the index adders.

Test Plan:
- Nominal instruction: uop_bgn=1, uop_end=2, iter_out=16, iter_in=1, dst_out=1, src_out=1, other factors 0; uop[1] = dst 4, src 8, wgt 3.
  - Expect 16 issues in cycles 3..18 with acc_idx=4..19, inp_idx=8..23, wgt_idx=3.
  - done in cycle 19; upc=1 throughout.
- Nested loops: bgn=0, end=2, iter_out=2, iter_in=3, dst_out=10, dst_in=1, src_in=2, wgt_out=5.
  - Expect 12 issues, acc_idx sequence in iteration order 0,0,1,1,2,2,10,10,11,11,12,12 plus uop.dst.
  - wgt offset changes only at i_out=1.
- Empty instruction (iter_in=0, and separately opcode=3) -> no issue_valid, done 2 cycles after accept, insn_ready back high.
- Wrap and reset flag: uop.dst=2040, dst_out=8, iter_out=2 -> acc_idx=2040 then 0. With insn[7]=1, issue_reset=1 on every issue.
- en deasserted for 3 cycles mid-RUN -> upc, outputs and counters hold; sequence resumes with no skipped or duplicated issue; done is delayed by exactly 3 cycles.
- rst pulsed during RUN -> next cycle: insn_ready=1, issue_valid=0, no done; a fresh instruction then runs correctly.
